// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache line refill engine.
package cache_axi_pkg;

  localparam int unsigned LINE_WORDS_DEFAULT = 16;
  localparam int unsigned WORD_W             = 32;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } refill_state_e;

  // AXI read/write address channel payload
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ax_t;

  // Clears the byte-offset bits that address inside one cache line.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned line_words);
    return addr & ~(32'(line_words * 4) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// One cache line of storage: parallel load of the victim, word-wise fill from
// the read channel and word-wise readout for the write channel.
module cache_line_buf
  import cache_axi_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
  localparam int unsigned LINE_BITS  = WORD_W * LINE_WORDS,
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD_W-1:0]    rd_word_c,
  output logic [LINE_BITS-1:0] line
);

  logic [LINE_WORDS-1:0][WORD_W-1:0] words;

  // Victim load has priority; it never coincides with a fill beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words <= '0;
    end else if (load) begin
      words <= load_line;
    end else if (wr_en) begin
      words[wr_idx] <= wr_word;
    end
  end

  assign rd_word_c = words[rd_idx];
  assign line      = words;

endmodule

// File: rtl/cache_axi_refill.sv
// Services cache line misses over AXI4: optional dirty-victim write-back,
// then a burst read of the new line, finished with a one-cycle refresh pulse.
module cache_axi_refill
  import cache_axi_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
  localparam int unsigned LINE_BITS  = WORD_W * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss,
  input  logic [31:0]          axi_raddr,
  input  logic                 write_back,
  input  logic [31:0]          axi_waddr,
  input  logic [LINE_BITS-1:0] cacheline_old,
  output logic                 refresh,
  output logic [LINE_BITS-1:0] cacheline_new,
  output logic                 busy,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [31:0]          rdata,
  input  logic                 rvalid,
  input  logic                 rlast,
  input  logic [1:0]           rresp,
  output logic                 rready,
  output logic [31:0]          awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic                 bvalid,
  input  logic [1:0]           bresp,
  output logic                 bready
);

  localparam int unsigned     IDX_W     = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);
  localparam logic [7:0]       BURST_LEN = 8'(LINE_WORDS - 1);

  refill_state_e    state, state_next;
  logic [IDX_W-1:0] beat, beat_next;
  logic [31:0]      raddr_q, waddr_q;
  logic             latch_req, load_victim, fill_we;
  logic [31:0]      buf_rd_word;
  axi_ax_t          ar_req, aw_req;

  // Completion is beat-count based, so these responses carry no information here.
  logic unused_resp;
  assign unused_resp = ^{rlast, rresp, bresp};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Handshakes key off state alone: each valid/ready output is high exactly in its state.
  always_comb begin
    state_next  = state;
    beat_next   = beat;
    latch_req   = 1'b0;
    load_victim = 1'b0;
    fill_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (miss) begin
          latch_req = 1'b1;
          if (write_back) begin
            load_victim = 1'b1;
            state_next  = ST_AW;
          end else begin
            state_next = ST_AR;
          end
        end
      end
      ST_AW: begin
        if (awready) begin
          state_next = ST_W;
          beat_next  = '0;
        end
      end
      ST_W: begin
        if (wready) begin
          if (beat == LAST_BEAT) state_next = ST_B;
          else                   beat_next  = beat + IDX_W'(1);
        end
      end
      ST_B: begin
        if (bvalid) state_next = ST_AR;
      end
      ST_AR: begin
        if (arready) begin
          state_next = ST_R;
          beat_next  = '0;
        end
      end
      ST_R: begin
        if (rvalid) begin
          fill_we = 1'b1;
          if (beat == LAST_BEAT) state_next = ST_DONE;
          else                   beat_next  = beat + IDX_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      wdata   <= '0;
      bready  <= 1'b0;
      refresh <= 1'b0;
      busy    <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
    end else begin
      arvalid <= (state_next == ST_AR);
      rready  <= (state_next == ST_R);
      awvalid <= (state_next == ST_AW);
      wvalid  <= (state_next == ST_W);
      wlast   <= (state_next == ST_W) && (beat_next == LAST_BEAT);
      wdata   <= buf_rd_word;
      bready  <= (state_next == ST_B);
      refresh <= (state_next == ST_DONE);
      busy    <= (state_next != ST_IDLE);
      if (latch_req)   raddr_q <= line_align(axi_raddr, LINE_WORDS);
      if (load_victim) waddr_q <= line_align(axi_waddr, LINE_WORDS);
    end
  end

  assign ar_req = '{addr: raddr_q, len: BURST_LEN, size: AXI_SIZE_4B, burst: AXI_BURST_INCR};
  assign aw_req = '{addr: waddr_q, len: BURST_LEN, size: AXI_SIZE_4B, burst: AXI_BURST_INCR};

  assign araddr  = ar_req.addr;
  assign arlen   = ar_req.len;
  assign arsize  = ar_req.size;
  assign arburst = ar_req.burst;
  assign awaddr  = aw_req.addr;
  assign awlen   = aw_req.len;
  assign awsize  = aw_req.size;
  assign awburst = aw_req.burst;
  assign wstrb   = 4'hF;

  cache_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load_victim),
    .load_line (cacheline_old),
    .wr_en     (fill_we),
    .wr_idx    (beat),
    .wr_word   (rdata),
    .rd_idx    (beat_next),
    .rd_word_c (buf_rd_word),
    .line      (cacheline_new)
  );

endmodule

// File: tb/tb_cache_axi_refill.sv
// Self-checking bench for cache_axi_refill: randomizing AXI slave, vector table,
// random misses and hand-written corner sequences.
module tb_cache_axi_refill;

  localparam int LW = 16;
  localparam int LB = 32 * LW;

  logic          clk, rst, miss, write_back;
  logic [31:0]   axi_raddr, axi_waddr;
  logic [LB-1:0] cacheline_old, cacheline_new;
  logic          refresh, busy;
  logic [31:0]   araddr, awaddr, rdata, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst, rresp, bresp;
  logic          arvalid, arready, rvalid, rlast, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb;

  cache_axi_refill #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .miss(miss), .axi_raddr(axi_raddr), .write_back(write_back),
    .axi_waddr(axi_waddr), .cacheline_old(cacheline_old), .refresh(refresh),
    .cacheline_new(cacheline_new), .busy(busy),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  int n_checks, n_fails;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Slave configuration and what it observed on the bus.
  int unsigned stall_pct;
  bit          early_rlast;
  logic [31:0] rd_mem [LW];
  logic [31:0] old_mem [LW];
  logic [31:0] aw_addr_q[$], ar_addr_q[$], w_data_q[$];
  logic [7:0]  aw_len_q[$], ar_len_q[$];
  bit          w_last_q[$];
  bit          b_outstanding;
  int          refresh_cnt;

  function automatic bit chance();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  // AXI slave: drives its side on negedge, logs handshakes that fire at the next posedge.
  initial begin : slave
    int r_left, r_idx, b_pend;
    bit r_acc, b_acc, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_wlast;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    r_left = 0; r_idx = 0; b_pend = 0; r_acc = 0; b_acc = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_wlast = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0;
    refresh_cnt = 0; b_outstanding = 0;
    awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0; rlast = 0;
    rresp = '0; bvalid = 0; bresp = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0; rlast = 0; bvalid = 0;
        r_left = 0; r_idx = 0; b_pend = 0; r_acc = 0; b_acc = 0; b_outstanding = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
        continue;
      end
      if (p_awv && !p_awr) begin
        check("aw_hold_valid", 32'(awvalid), 1);
        check("aw_hold_addr", awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        check("w_hold_valid", 32'(wvalid), 1);
        check("w_hold_data", wdata, p_wdata);
        check("w_hold_last", 32'(wlast), 32'(p_wlast));
      end
      if (p_arv && !p_arr) begin
        check("ar_hold_valid", 32'(arvalid), 1);
        check("ar_hold_addr", araddr, p_araddr);
      end
      if (r_acc) rvalid = 0;
      if (b_acc) bvalid = 0;
      awready = chance();
      wready  = chance();
      arready = chance();
      if (!bvalid && b_pend > 0 && chance()) begin
        bvalid = 1;
        bresp  = 2'($urandom_range(3));
      end
      if (!rvalid && r_left > 0 && chance()) begin
        rvalid = 1;
        rdata  = rd_mem[r_idx];
        rlast  = (r_idx == LW - 1) || (early_rlast && r_idx == 7);
        rresp  = 2'($urandom_range(3));
      end
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        b_outstanding = 1;
      end
      if (wvalid && wready) begin
        w_data_q.push_back(wdata);
        w_last_q.push_back(wlast);
        check("wstrb", 32'(wstrb), 32'hF);
        if (wlast) b_pend++;
      end
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
        check("ar_after_b", 32'(b_outstanding), 0);
        check("ar_size_burst", {27'd0, arsize, arburst}, {27'd0, 3'd2, 2'b01});
        r_left = int'(arlen) + 1;
        r_idx  = 0;
      end
      b_acc = bvalid && bready;
      if (b_acc) begin
        b_pend--;
        b_outstanding = 0;
      end
      r_acc = rvalid && rready;
      if (r_acc) begin
        r_left--;
        r_idx++;
      end
      if (refresh) refresh_cnt++;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    miss = 0;
    write_back = 0;
    rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  function automatic void clear_logs();
    aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
    w_data_q.delete(); w_last_q.delete();
  endfunction

  // One miss; expected line is rd_mem, expected write-back beats are old_mem.
  task automatic run_txn(input logic [31:0] raddr, input logic [31:0] waddr, input bit wb,
                         input logic [31:0] exp_araddr, input logic [31:0] exp_awaddr,
                         input int unsigned exp_lat);
    int unsigned start, lat;
    int base_ref;
    bit got;
    clear_logs();
    base_ref   = refresh_cnt;
    axi_raddr  = raddr;
    axi_waddr  = waddr;
    write_back = wb;
    for (int i = 0; i < LW; i++) cacheline_old[32*i +: 32] = old_mem[i];
    miss  = 1;
    start = cyc;
    got   = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (refresh) begin
        got = 1;
        break;
      end
    end
    check("refresh_seen", 32'(got), 1);
    if (!got) begin
      do_reset();
      return;
    end
    lat = cyc - start;
    if (exp_lat != 0) check("refresh_latency", lat, exp_lat);
    miss = 0;
    write_back = 0;
    for (int i = 0; i < LW; i++)
      check($sformatf("line_word[%0d]", i), cacheline_new[32*i +: 32], rd_mem[i]);
    @(negedge clk);
    check("refresh_one_cycle", 32'(refresh), 0);
    check("busy_after_done", 32'(busy), 0);
    check("refresh_count", 32'(refresh_cnt - base_ref), 1);
    check("ar_count", 32'(ar_addr_q.size()), 1);
    if (ar_addr_q.size() > 0) begin
      check("araddr", ar_addr_q[0], exp_araddr);
      check("arlen", 32'(ar_len_q[0]), LW - 1);
    end
    if (wb) begin
      check("aw_count", 32'(aw_addr_q.size()), 1);
      if (aw_addr_q.size() > 0) begin
        check("awaddr", aw_addr_q[0], exp_awaddr);
        check("awlen", 32'(aw_len_q[0]), LW - 1);
      end
      check("w_beats", 32'(w_data_q.size()), LW);
      for (int i = 0; i < LW && i < w_data_q.size(); i++) begin
        check($sformatf("wdata[%0d]", i), w_data_q[i], old_mem[i]);
        check($sformatf("wlast[%0d]", i), 32'(w_last_q[i]), (i == LW - 1) ? 1 : 0);
      end
    end else begin
      check("aw_count_clean", 32'(aw_addr_q.size()), 0);
      check("w_beats_clean", 32'(w_data_q.size()), 0);
    end
    repeat (3) @(negedge clk);
    check("line_hold_first", cacheline_new[31:0], rd_mem[0]);
    check("line_hold_last", cacheline_new[LB-1 -: 32], rd_mem[LW-1]);
  endtask

  typedef struct {
    logic [31:0] raddr;
    logic [31:0] waddr;
    bit          wb;
    logic [31:0] old_base;
    logic [31:0] rd_base;
    int unsigned stall;
    bit          early;
    logic [31:0] exp_araddr;
    logic [31:0] exp_awaddr;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    logic [31:0] r, w;
    bit wb, got;
    int base_ref;
    vecs[0] = '{raddr: 32'h1000_0024, waddr: 32'h0, wb: 0, old_base: 32'h0, rd_base: 32'hA0,
                stall: 0, early: 0, exp_araddr: 32'h1000_0000, exp_awaddr: 32'h0, exp_lat: 18};
    vecs[1] = '{raddr: 32'h3000_1234, waddr: 32'h2000_0040, wb: 1, old_base: 32'h100,
                rd_base: 32'hB00, stall: 0, early: 0, exp_araddr: 32'h3000_1200,
                exp_awaddr: 32'h2000_0040, exp_lat: 36};
    vecs[2] = '{raddr: 32'h0000_007C, waddr: 32'h0, wb: 0, old_base: 32'h0, rd_base: 32'hC0,
                stall: 0, early: 1, exp_araddr: 32'h0000_0040, exp_awaddr: 32'h0, exp_lat: 18};
    vecs[3] = '{raddr: 32'hFFFF_FFFF, waddr: 32'h2000_007F, wb: 1, old_base: 32'h5500,
                rd_base: 32'hD000, stall: 50, early: 0, exp_araddr: 32'hFFFF_FFC0,
                exp_awaddr: 32'h2000_0040, exp_lat: 0};
    vecs[4] = '{raddr: 32'h8000_0010, waddr: 32'h0, wb: 0, old_base: 32'h0, rd_base: 32'hE0E0,
                stall: 50, early: 1, exp_araddr: 32'h8000_0000, exp_awaddr: 32'h0, exp_lat: 0};

    n_checks = 0; n_fails = 0;
    stall_pct = 0; early_rlast = 0;
    rst = 0; miss = 0; write_back = 0; axi_raddr = '0; axi_waddr = '0; cacheline_old = '0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_refresh", 32'(refresh), 0);
    check("rst_busy", 32'(busy), 0);
    for (int i = 0; i < LW; i++)
      check($sformatf("rst_line[%0d]", i), cacheline_new[32*i +: 32], 0);
    rst = 1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      stall_pct   = vecs[v].stall;
      early_rlast = vecs[v].early;
      for (int i = 0; i < LW; i++) begin
        rd_mem[i]  = vecs[v].rd_base + 32'(i);
        old_mem[i] = vecs[v].old_base + 32'(i);
      end
      run_txn(vecs[v].raddr, vecs[v].waddr, vecs[v].wb,
              vecs[v].exp_araddr, vecs[v].exp_awaddr, vecs[v].exp_lat);
    end

    // Random misses with 50% stalls on every slave handshake.
    for (int t = 0; t < 12; t++) begin
      stall_pct   = 50;
      early_rlast = 1'($urandom_range(1));
      r  = $urandom();
      w  = $urandom();
      wb = 1'($urandom_range(1));
      for (int i = 0; i < LW; i++) begin
        rd_mem[i]  = $urandom();
        old_mem[i] = $urandom();
      end
      run_txn(r, w, wb, (r / 32'(LW * 4)) * 32'(LW * 4), (w / 32'(LW * 4)) * 32'(LW * 4), 0);
    end

    // Reset during write beat 5 aborts at once and leaves no stale refresh.
    stall_pct = 0; early_rlast = 0;
    for (int i = 0; i < LW; i++) begin
      old_mem[i] = 32'h100 + 32'(i);
      rd_mem[i]  = 32'hA0 + 32'(i);
    end
    for (int i = 0; i < LW; i++) cacheline_old[32*i +: 32] = old_mem[i];
    axi_raddr = 32'h1000_0024; axi_waddr = 32'h2000_0040; write_back = 1; miss = 1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wvalid) begin
        got = 1;
        break;
      end
    end
    check("rstw_reached_w", 32'(got), 1);
    repeat (5) @(negedge clk);
    check("rstw_beat5_data", wdata, old_mem[5]);
    #1 rst = 0;
    #1;
    check("rstw_wvalid", 32'(wvalid), 0);
    check("rstw_awvalid", 32'(awvalid), 0);
    check("rstw_arvalid", 32'(arvalid), 0);
    check("rstw_rready", 32'(rready), 0);
    check("rstw_bready", 32'(bready), 0);
    check("rstw_busy", 32'(busy), 0);
    miss = 0; write_back = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    base_ref = refresh_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstw_no_refresh", 32'(refresh), 0);
      check("rstw_idle", 32'(busy), 0);
    end
    check("rstw_refresh_cnt", 32'(refresh_cnt - base_ref), 0);
    run_txn(32'h1000_0024, 32'h0, 0, 32'h1000_0000, 32'h0, 18);

    // miss held across refresh starts a second fill straight after DONE.
    clear_logs();
    base_ref = refresh_cnt;
    for (int i = 0; i < LW; i++) rd_mem[i] = 32'h700 + 32'(i);
    axi_raddr = 32'h4000_0088; write_back = 0; miss = 1;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (refresh) begin
        got = 1;
        break;
      end
    end
    check("held_first_refresh", 32'(got), 1);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 0);
    check("held_idle_arvalid", 32'(arvalid), 0);
    @(negedge clk);
    check("held_restart_arvalid", 32'(arvalid), 1);
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (refresh) begin
        got = 1;
        break;
      end
    end
    miss = 0;
    check("held_second_refresh", 32'(got), 1);
    @(negedge clk);
    check("held_refresh_cnt", 32'(refresh_cnt - base_ref), 2);
    check("held_ar_count", 32'(ar_addr_q.size()), 2);
    if (ar_addr_q.size() == 2) check("held_araddr2", ar_addr_q[1], 32'h4000_0080);

    // write_back without miss must not start anything.
    clear_logs();
    axi_waddr = 32'h2222_0000; axi_raddr = 32'h3333_0000; write_back = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("wbonly_busy", 32'(busy), 0);
      check("wbonly_awvalid", 32'(awvalid), 0);
      check("wbonly_arvalid", 32'(arvalid), 0);
    end
    write_back = 0;
    @(negedge clk);
    check("wbonly_aw_count", 32'(aw_addr_q.size()), 0);
    check("wbonly_ar_count", 32'(ar_addr_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
